// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder: Clause-22 MDIO management responder (PHY side).
// Oversamples MDC on clk_rmii, decodes read/write frames addressed to PHY_ADDR
// and serves a small PHY register file (BMCR, BMSR, PHYIDR1/2, ANAR).
//
// Optional build macro: MDIO_PREAMBLE_SUPPRESS_EN
//   defined   -> a frame start is accepted after >=1 sampled preamble one, BMSR[6]=1
//   undefined -> PRE_LEN consecutive ones are required, BMSR[6]=0
//
// Ports:
//   clk_rmii   in   RMII clock, all logic on its rising edge
//   rstn       in   synchronous active-low reset
//   mdc        in   MDC from the MAC (asynchronous, synchronised here)
//   mdio_i     in   MDIO line input (asynchronous, synchronised here)
//   mdio_o     out  MDIO output data
//   mdio_oe    out  MDIO output enable (1 = responder drives the line)
//   link_up    in   link status, reflected in BMSR[2]
//   phy_reset  out  one-cycle pulse on a write of BMCR[15]=1
//   loopback   out  BMCR[14]
//   wr_strobe  out  one-cycle pulse on every accepted write to this PHY
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0007,
  parameter logic [15:0] PHY_ID2  = 16'hC0F1,
  parameter int unsigned PRE_LEN  = 32
) (
  input  logic clk_rmii,
  input  logic rstn,
  input  logic mdc,
  input  logic mdio_i,
  output logic mdio_o,
  output logic mdio_oe,
  input  logic link_up,
  output logic phy_reset,
  output logic loopback,
  output logic wr_strobe
);

  // Counter serves both the preamble count and the in-field bit index (max 15).
  localparam int unsigned CNT_W = ($clog2(PRE_LEN + 1) > 4) ? $clog2(PRE_LEN + 1) : 4;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam int unsigned PRE_MIN = 1;
  localparam logic        PS_BIT  = 1'b1;
`else
  localparam int unsigned PRE_MIN = PRE_LEN;
  localparam logic        PS_BIT  = 1'b0;
`endif

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ST2   = 3'd1;
  localparam logic [2:0] S_OP    = 3'd2;
  localparam logic [2:0] S_PHYAD = 3'd3;
  localparam logic [2:0] S_REGAD = 3'd4;
  localparam logic [2:0] S_TA1   = 3'd5;
  localparam logic [2:0] S_TA2   = 3'd6;
  localparam logic [2:0] S_DATA  = 3'd7;

  // Input synchronisers and MDC edge detect
  logic mdc_m, mdc_s, mdc_q;
  logic mdio_m, mdio_s;
  logic rise;

  always_ff @(posedge clk_rmii) begin
    if (!rstn) begin
      mdc_m  <= 1'b0;
      mdc_s  <= 1'b0;
      mdc_q  <= 1'b0;
      mdio_m <= 1'b0;
      mdio_s <= 1'b0;
    end else begin
      mdc_m  <= mdc;
      mdc_s  <= mdc_m;
      mdc_q  <= mdc_s;
      mdio_m <= mdio_i;
      mdio_s <= mdio_m;
    end
  end

  assign rise = mdc_s & ~mdc_q;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_first_q, op_first_d;
  logic             is_read_q, is_read_d;
  logic [4:0]       phyad_q, phyad_d;
  logic [4:0]       regad_q, regad_d;
  logic [15:0]      sh_q, sh_d;
  logic             mdio_o_q, mdio_o_d;
  logic             mdio_oe_q, mdio_oe_d;
  logic             lb_q, lb_d;
  logic             b13_q, b13_d;
  logic             b12_q, b12_d;
  logic             b8_q, b8_d;
  logic [10:0]      anar_q, anar_d;
  logic             wr_strobe_q, wr_strobe_d;
  logic             phy_reset_q, phy_reset_d;
  logic             match;
  logic [15:0]      rdata;
  logic [15:0]      wdata;

  assign match = (phyad_q == PHY_ADDR);

  // Register file read view
  always_comb begin
    rdata = 16'h0000;
    case (regad_q)
      5'd0:    rdata = {1'b0, lb_q, b13_q, b12_q, 3'b000, b8_q, 8'h00};
      5'd1:    rdata = 16'h7809 | {13'd0, link_up, 2'b00} | {9'd0, PS_BIT, 6'd0};
      5'd2:    rdata = PHY_ID1;
      5'd3:    rdata = PHY_ID2;
      5'd4:    rdata = {anar_q, 5'b00001};
      default: rdata = 16'h0000;
    endcase
  end

  // Frame decoder: next state and next value of every register
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_first_d  = op_first_q;
    is_read_d   = is_read_q;
    phyad_d     = phyad_q;
    regad_d     = regad_q;
    sh_d        = sh_q;
    mdio_o_d    = mdio_o_q;
    mdio_oe_d   = mdio_oe_q;
    lb_d        = lb_q;
    b13_d       = b13_q;
    b12_d       = b12_q;
    b8_d        = b8_q;
    anar_d      = anar_q;
    wr_strobe_d = 1'b0;
    phy_reset_d = 1'b0;
    wdata       = {sh_q[14:0], mdio_s};

    if (rise) begin
      case (state_q)
        S_IDLE: begin
          if (mdio_s) begin
            if (cnt_q < CNT_W'(PRE_LEN)) cnt_d = cnt_q + CNT_W'(1);
          end else begin
            // A zero is the first start bit only after enough preamble
            if (cnt_q >= CNT_W'(PRE_MIN)) state_d = S_ST2;
            cnt_d = '0;
          end
        end
        S_ST2: begin
          state_d = mdio_s ? S_OP : S_IDLE;
          cnt_d   = '0;
        end
        S_OP: begin
          if (cnt_q == '0) begin
            op_first_d = mdio_s;
            cnt_d      = CNT_W'(1);
          end else begin
            cnt_d = '0;
            // 10 = read, 01 = write; 00/11 abandon the frame
            if (op_first_q != mdio_s) begin
              is_read_d = op_first_q;
              state_d   = S_PHYAD;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_PHYAD: begin
          phyad_d = {phyad_q[3:0], mdio_s};
          if (cnt_q == CNT_W'(4)) begin
            cnt_d   = '0;
            state_d = S_REGAD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_REGAD: begin
          regad_d = {regad_q[3:0], mdio_s};
          if (cnt_q == CNT_W'(4)) begin
            cnt_d   = '0;
            state_d = S_TA1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_TA1: begin
          state_d = S_TA2;
          // Snapshot read data now so the whole word is coherent
          if (is_read_q && match) begin
            mdio_oe_d = 1'b1;
            mdio_o_d  = 1'b0;
            sh_d      = rdata;
          end
        end
        S_TA2: begin
          state_d = S_DATA;
          cnt_d   = '0;
          if (is_read_q && match) begin
            mdio_o_d = sh_q[15];
            sh_d     = {sh_q[14:0], 1'b0};
          end
        end
        S_DATA: begin
          if (is_read_q) begin
            if (match) begin
              if (cnt_q == CNT_W'(15)) begin
                mdio_oe_d = 1'b0;
                mdio_o_d  = 1'b0;
              end else begin
                mdio_o_d = sh_q[15];
                sh_d     = {sh_q[14:0], 1'b0};
              end
            end
          end else begin
            sh_d = wdata;
            if (match && cnt_q == CNT_W'(15)) begin
              wr_strobe_d = 1'b1;
              case (regad_q)
                5'd0: begin
                  if (wdata[15]) begin
                    // Soft reset: pulse and restore BMCR defaults
                    phy_reset_d = 1'b1;
                    lb_d        = 1'b0;
                    b13_d       = 1'b1;
                    b12_d       = 1'b1;
                    b8_d        = 1'b1;
                  end else begin
                    lb_d  = wdata[14];
                    b13_d = wdata[13];
                    b12_d = wdata[12];
                    b8_d  = wdata[8];
                  end
                end
                5'd4:    anar_d = wdata[15:5];
                default: ;
              endcase
            end
          end
          if (cnt_q == CNT_W'(15)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_rmii) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_first_q  <= 1'b0;
      is_read_q   <= 1'b0;
      phyad_q     <= 5'd0;
      regad_q     <= 5'd0;
      sh_q        <= 16'h0000;
      mdio_o_q    <= 1'b0;
      mdio_oe_q   <= 1'b0;
      lb_q        <= 1'b0;
      b13_q       <= 1'b1;
      b12_q       <= 1'b1;
      b8_q        <= 1'b1;
      anar_q      <= 11'h00F;
      wr_strobe_q <= 1'b0;
      phy_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_first_q  <= op_first_d;
      is_read_q   <= is_read_d;
      phyad_q     <= phyad_d;
      regad_q     <= regad_d;
      sh_q        <= sh_d;
      mdio_o_q    <= mdio_o_d;
      mdio_oe_q   <= mdio_oe_d;
      lb_q        <= lb_d;
      b13_q       <= b13_d;
      b12_q       <= b12_d;
      b8_q        <= b8_d;
      anar_q      <= anar_d;
      wr_strobe_q <= wr_strobe_d;
      phy_reset_q <= phy_reset_d;
    end
  end

  assign mdio_o    = mdio_o_q;
  assign mdio_oe   = mdio_oe_q;
  assign loopback  = lb_q;
  assign wr_strobe = wr_strobe_q;
  assign phy_reset = phy_reset_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// tb_mdio_phy_responder: bit-bangs MDIO frames at mdio_phy_responder and
// compares read data, drive windows and side effects against a register model.
module tb_mdio_phy_responder;

  localparam int unsigned PRE = 32;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam int unsigned PRE_MIN = 1;
  localparam logic [15:0] PS_MASK = 16'h0040;
`else
  localparam int unsigned PRE_MIN = PRE;
  localparam logic [15:0] PS_MASK = 16'h0000;
`endif

  logic clk_rmii = 1'b0;
  logic rstn     = 1'b0;
  logic mdc      = 1'b0;
  logic mdio_drv = 1'b1;
  logic link_up  = 1'b0;
  logic mdio_line;
  logic mdio_o, mdio_oe, phy_reset, loopback, wr_strobe;

  int n_cmp   = 0;
  int n_err   = 0;
  int wr_cnt  = 0;
  int rst_cnt = 0;

  // Reference register model
  logic [15:0] m_bmcr = 16'h3100;
  logic [15:0] m_anar = 16'h01E1;
  int          m_wr   = 0;
  int          m_rst  = 0;

  // Shared MDIO line: responder wins while it drives, else the master's value
  assign mdio_line = mdio_oe ? mdio_o : mdio_drv;

  mdio_phy_responder #(
    .PHY_ADDR(5'd1),
    .PHY_ID1 (16'h0007),
    .PHY_ID2 (16'hC0F1),
    .PRE_LEN (PRE)
  ) dut (
    .clk_rmii (clk_rmii),
    .rstn     (rstn),
    .mdc      (mdc),
    .mdio_i   (mdio_line),
    .mdio_o   (mdio_o),
    .mdio_oe  (mdio_oe),
    .link_up  (link_up),
    .phy_reset(phy_reset),
    .loopback (loopback),
    .wr_strobe(wr_strobe)
  );

  always #10 clk_rmii = ~clk_rmii;

  // Count high cycles of the pulse outputs
  always @(negedge clk_rmii) begin
    if (wr_strobe) wr_cnt <= wr_cnt + 1;
    if (phy_reset) rst_cnt <= rst_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [4:0] ra);
    case (ra)
      5'd0:    return m_bmcr;
      5'd1:    return 16'h7809 | (link_up ? 16'h0004 : 16'h0000) | PS_MASK;
      5'd2:    return 16'h0007;
      5'd3:    return 16'hC0F1;
      5'd4:    return m_anar;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic m_write(input logic [4:0] ra, input logic [15:0] wd);
    m_wr++;
    if (ra == 5'd0) begin
      if (wd[15]) begin
        m_bmcr = 16'h3100;
        m_rst++;
      end else begin
        m_bmcr = wd & 16'h7100;
      end
    end else if (ra == 5'd4) begin
      m_anar = (wd & 16'hFFE0) | 16'h0001;
    end
  endtask

  // One MDC period: sample the line just before the rising edge
  task automatic mdc_bit(input logic b, output logic o, output logic oe);
    mdc      = 1'b0;
    mdio_drv = b;
    repeat (4) @(negedge clk_rmii);
    o   = mdio_o;
    oe  = mdio_oe;
    mdc = 1'b1;
    repeat (4) @(negedge clk_rmii);
  endtask

  task automatic send_frame(input int pre, input logic [1:0] op, input logic [4:0] pa,
                            input logic [4:0] ra, input logic [15:0] wd, input int stop_at,
                            output logic [15:0] rd, output logic ta2_o, output int oe_hits);
    bit   bits[$];
    logic o, oe;
    rd      = 16'h0000;
    ta2_o   = 1'b1;
    oe_hits = 0;
    for (int i = 0; i < pre; i++) bits.push_back(1'b1);
    bits.push_back(1'b0);
    bits.push_back(1'b1);
    bits.push_back(op[1]);
    bits.push_back(op[0]);
    for (int i = 4; i >= 0; i--) bits.push_back(pa[i]);
    for (int i = 4; i >= 0; i--) bits.push_back(ra[i]);
    bits.push_back(1'b1);
    bits.push_back(op == 2'b10 ? 1'b1 : 1'b0);
    for (int i = 15; i >= 0; i--) bits.push_back(op == 2'b10 ? 1'b1 : wd[i]);
    for (int i = 0; i < bits.size(); i++) begin
      if (stop_at >= 0 && i == stop_at) return;
      mdc_bit(bits[i], o, oe);
      if (oe) oe_hits++;
      if (i == pre + 15) ta2_o = o;
      if (i >= pre + 16) rd[15 - (i - pre - 16)] = o;
    end
    mdc      = 1'b0;
    mdio_drv = 1'b1;
    repeat (8) @(negedge clk_rmii);
  endtask

  task automatic run_frame(input int pre, input logic [1:0] op, input logic [4:0] pa,
                           input logic [4:0] ra, input logic [15:0] wd, input string tag);
    logic [15:0] exp_rd;
    logic [15:0] rd;
    logic        t2;
    int          hits;
    bit          resp, wr;
    exp_rd = m_read(ra);
    resp   = (pre >= PRE_MIN) && (op == 2'b10) && (pa == 5'd1);
    wr     = (pre >= PRE_MIN) && (op == 2'b01) && (pa == 5'd1);
    send_frame(pre, op, pa, ra, wd, -1, rd, t2, hits);
    chk({tag, " oe_bits"}, hits, resp ? 17 : 0);
    if (resp) begin
      chk({tag, " ta2_o"}, t2, 0);
      chk({tag, " rdata"}, rd, exp_rd);
    end
    if (wr) m_write(ra, wd);
    chk({tag, " oe_after"}, mdio_oe, 0);
    chk({tag, " loopback"}, loopback, m_bmcr[14]);
    chk({tag, " wr_pulses"}, wr_cnt, m_wr);
    chk({tag, " rst_pulses"}, rst_cnt, m_rst);
  endtask

  initial begin
    logic [15:0] rd;
    logic        t2;
    int          hits;
    logic [1:0]  op;
    logic [4:0]  pa;
    int          r;

    repeat (4) @(negedge clk_rmii);
    chk("rst mdio_oe", mdio_oe, 0);
    chk("rst mdio_o", mdio_o, 0);
    chk("rst phy_reset", phy_reset, 0);
    chk("rst loopback", loopback, 0);
    chk("rst wr_strobe", wr_strobe, 0);
    rstn = 1'b1;
    repeat (4) @(negedge clk_rmii);

    run_frame(PRE, 2'b10, 5'd1, 5'd2, 16'h0000, "rd_id1");
    run_frame(PRE, 2'b10, 5'd1, 5'd0, 16'h0000, "rd_bmcr_rst");
    run_frame(PRE, 2'b01, 5'd1, 5'd0, 16'h7100, "wr_lb");
    run_frame(PRE, 2'b10, 5'd1, 5'd0, 16'h0000, "rd_lb");
    run_frame(PRE, 2'b01, 5'd1, 5'd0, 16'h8000, "wr_softrst");
    run_frame(PRE, 2'b10, 5'd1, 5'd0, 16'h0000, "rd_after_rst");
    run_frame(PRE, 2'b10, 5'd5, 5'd2, 16'h0000, "rd_other_phy");
    run_frame(PRE, 2'b10, 5'd1, 5'd3, 16'h0000, "rd_id2");
    run_frame(PRE - 1, 2'b10, 5'd1, 5'd2, 16'h0000, "short_pre");
    run_frame(PRE, 2'b10, 5'd1, 5'd4, 16'h0000, "rd_anar");
    run_frame(PRE, 2'b01, 5'd1, 5'd4, 16'hFFFF, "wr_anar");
    run_frame(PRE, 2'b10, 5'd1, 5'd4, 16'h0000, "rd_anar2");

    for (int i = 0; i < 40; i++) begin
      link_up = 1'($urandom_range(0, 1));
      r       = int'($urandom_range(0, 9));
      op      = (r < 5) ? 2'b10 : 2'b01;
`ifndef MDIO_PREAMBLE_SUPPRESS_EN
      if (r == 9) op = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
`endif
      pa = ($urandom_range(0, 3) != 0) ? 5'd1 : 5'($urandom_range(0, 31));
      run_frame(PRE + int'($urandom_range(0, 4)), op, pa, 5'($urandom_range(0, 7)),
                16'($urandom), $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a read data phase
    send_frame(PRE, 2'b10, 5'd1, 5'd3, 16'h0000, PRE + 21, rd, t2, hits);
    mdc = 1'b0;
    repeat (2) @(negedge clk_rmii);
    chk("midrst oe_before", mdio_oe, 1);
    rstn = 1'b0;
    @(posedge clk_rmii);
    #1;
    chk("midrst oe_after", mdio_oe, 0);
    repeat (3) @(negedge clk_rmii);
    m_bmcr = 16'h3100;
    m_anar = 16'h01E1;
    rstn   = 1'b1;
    repeat (4) @(negedge clk_rmii);
    link_up = 1'b1;
    run_frame(PRE, 2'b10, 5'd1, 5'd1, 16'h0000, "rd_bmsr_link");
    run_frame(PRE, 2'b10, 5'd1, 5'd4, 16'h0000, "rd_anar_post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
